int_ctl: RTL and testbench
==========================

INT_CTL -- requirements
Module: int_ctl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset_n  in  1  synchronous active-low reset.
REQ-004 irq_n  in  1  external IRQ pin; level-sensitive, active-low, asynchronous to clk.
REQ-005 nmi_n  in  1  external NMI pin; falling-edge-sensitive, asynchronous to clk.
REQ-006 sync  in  1  from sequencer; high in the cycle the next opcode is decoded.
REQ-007 I  in  1  processor status I flag.
REQ-008 wai  in  1  one-cycle pulse when WAI executes.
REQ-009 stp  in  1  one-cycle pulse when STP executes.
REQ-010 irq  out  1  interrupt request to sequencer.
REQ-011 mask  out  1  effective mask to sequencer's I input.
REQ-012 vec_lo  out  8  low byte of vector address: FC reset, FA NMI, FE IRQ/BRK.
REQ-013 rdy  out  1  high = core may advance; low = core stalled.
REQ-014 cpu_reset  out  1  stretched active-high reset to sequencer.

Function
REQ-015 irq_n, nmi_n SHALL each pass a 2-flop synchronizer, flops reset to 1; sampled changes visible internally 2 cycles after the pin.
REQ-016 irq_pend SHALL equal the inverted synchronized irq_n; no latching.
REQ-017 nmi_pend SHALL set on a 1->0 transition of synchronized nmi_n; NMI held low SHALL produce exactly one request.
REQ-018 irq output SHALL equal nmi_pend | irq_pend.
REQ-019 mask output SHALL equal I & ~nmi_pend, so NMI bypasses the I flag.
REQ-020 Acceptance SHALL occur in a cycle with sync=1, irq=1, mask=0, rdy=1, cpu_reset=0.
REQ-021 On acceptance, NMI SHALL win if nmi_pend=1: vec_lo<=FA, nmi_pend cleared; otherwise vec_lo<=FE.
REQ-022 In any sync=1 cycle without acceptance, vec_lo SHALL load FE (BRK vector).
REQ-023 A new NMI edge in the same cycle as NMI acceptance SHALL leave nmi_pend=1.
REQ-024 Between sync cycles, vec_lo SHALL hold its value.
REQ-025 cpu_reset SHALL be 1 while reset_n=0 and for exactly 2 cycles after reset_n first samples 1, then 0.
REQ-026 State machine SHALL have states RUN, WAIT, STOP; rdy=1 only in RUN.
REQ-027 RUN->STOP on stp=1; RUN->WAIT on wai=1 with stp=0; stp SHALL win if both are high.
REQ-028 WAIT->RUN in the cycle after irq_pend=1 or nmi_pend=1, regardless of I.
REQ-029 In WAIT, nmi_pend SHALL NOT clear until acceptance in RUN.
REQ-030 STOP SHALL be left only by reset; in STOP, irq and nmi SHALL be ignored, but nmi_pend still updates.
REQ-031 wai and stp SHALL be ignored outside RUN.

Reset
REQ-032 When reset_n=0 at a clock edge, the block SHALL set irq=0, mask=1, vec_lo=FC, rdy=1, cpu_reset=1, state=RUN, nmi_pend=0, synchronizer flops=1.
REQ-033 Reset mid-WAIT or mid-STOP SHALL return to RUN with all outputs at their reset values.
REQ-034 vec_lo SHALL stay FC until the first sync=1 cycle after reset release.

Verification
REQ-035 Release reset_n at cycle 0 -> cpu_reset=1 on cycles 0-1, 0 from cycle 2; vec_lo=FC until the first sync.
REQ-036 irq_n=0, I=1 -> irq=1 and mask=1 after 2 cycles; at sync, vec_lo=FE and no acceptance; set I=0 -> accepted at the next sync.
REQ-037 nmi_n falls and stays low 20 cycles, I=1 -> mask=0 after 2 cycles; at sync, vec_lo=FA and nmi_pend clears; irq=0 thereafter with irq_n=1.
REQ-038 irq_n=0 and NMI edge together, sync=1 -> vec_lo=FA; irq stays 1 from irq_pend; the next sync yields FE.
REQ-039 wai pulse, then irq_n=0 five cycles later with I=1 -> rdy=0 from the cycle after wai, rdy=1 exactly one cycle after irq_pend rises.
REQ-040 wai=1 and stp=1 together -> STOP; rdy stays 0 through irq and NMI; reset_n=0 -> rdy=1 and vec_lo=FC.

Source files
------------

// File: rtl/int_ctl.sv
// -----------------------------------------------------------------------------
// int_ctl -- interrupt controller and run/wait/stop gate for a 65xx-style core.
//
// Purpose
//   Synchronizes the external IRQ (level, active-low) and NMI (falling edge)
//   pins, presents an interrupt request plus an effective I mask to the
//   instruction sequencer, selects the low byte of the vector fetch address,
//   stalls the core while WAI/STP are in effect, and stretches reset to the
//   sequencer.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   reset_n    in   synchronous active-low reset
//   irq_n      in   IRQ pin, level-sensitive, active-low, asynchronous to clk
//   nmi_n      in   NMI pin, falling-edge-sensitive, asynchronous to clk
//   sync       in   high in the cycle the next opcode is decoded
//   I          in   processor status I flag
//   wai        in   one-cycle pulse when WAI executes
//   stp        in   one-cycle pulse when STP executes
//   irq        out  interrupt request to the sequencer
//   mask       out  effective mask for the sequencer's I input
//   vec_lo     out  vector low byte: FC reset, FA NMI, FE IRQ/BRK
//   rdy        out  high = core may advance, low = core stalled
//   cpu_reset  out  stretched active-high reset to the sequencer
// -----------------------------------------------------------------------------
module int_ctl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       sync,
    input  logic       I,
    input  logic       wai,
    input  logic       stp,
    output logic       irq,
    output logic       mask,
    output logic [7:0] vec_lo,
    output logic       rdy,
    output logic       cpu_reset
);

    localparam logic [7:0] VEC_RESET = 8'hFC;
    localparam logic [7:0] VEC_NMI   = 8'hFA;
    localparam logic [7:0] VEC_IRQ   = 8'hFE;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Pin synchronizers: bit 0 = irq_n, bit 1 = nmi_n. Two flops each, both
    // forced high in reset so an idle (high) pin never looks like an event.
    // -------------------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;

    assign pin_raw = {nmi_n, irq_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] stage_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    stage_reg <= 2'b11;
                end else begin
                    stage_reg <= {stage_reg[0], pin_raw[gi]};
                end
            end

            assign pin_sync[gi] = stage_reg[1];
        end
    endgenerate

    logic irq_sync;
    logic nmi_sync;

    assign irq_sync = pin_sync[0];
    assign nmi_sync = pin_sync[1];

    // -------------------------------------------------------------------------
    // Pending requests.
    // nmi_prev_reg holds the previous synchronized NMI level so the falling
    // edge is seen in the same cycle the synchronized level drops. The edge is
    // folded combinationally into nmi_pend, which keeps NMI latency equal to
    // the synchronizer latency; nmi_pend_reg remembers it afterwards.
    // -------------------------------------------------------------------------
    logic nmi_prev_reg;
    logic nmi_pend_reg;
    logic nmi_pend_next;
    logic nmi_fall;
    logic nmi_pend;
    logic irq_pend;

    assign nmi_fall = nmi_prev_reg & ~nmi_sync;
    assign nmi_pend = nmi_pend_reg | nmi_fall;
    assign irq_pend = ~irq_sync;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_t     state_reg;
    state_t     state_next;
    logic [7:0] vec_lo_reg;
    logic [7:0] vec_lo_next;
    logic [1:0] stretch_cnt_reg;
    logic       cpu_reset_reg;
    logic       in_reset_reg;   // last edge sampled reset_n low
    logic       accept;
    logic       accept_nmi;

    assign rdy       = (state_reg == ST_RUN);
    assign irq       = nmi_pend | irq_pend;
    // NMI overrides the I flag; while reset is held the mask is forced on.
    assign mask      = (I & ~nmi_pend) | in_reset_reg;
    assign cpu_reset = cpu_reset_reg;
    assign vec_lo    = vec_lo_reg;

    assign accept     = sync & irq & ~mask & rdy & ~cpu_reset_reg;
    assign accept_nmi = accept & nmi_pend;

    // -------------------------------------------------------------------------
    // Next-state and next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        vec_lo_next   = vec_lo_reg;
        nmi_pend_next = nmi_pend;

        // Taking an NMI consumes one request. If the request being taken was
        // already latched and a fresh edge arrives in the same cycle, that
        // fresh edge must survive as a new request.
        if (accept_nmi) begin
            nmi_pend_next = nmi_pend_reg & nmi_fall;
        end

        // Every opcode fetch reloads the vector byte: NMI when an NMI is taken,
        // otherwise the shared IRQ/BRK vector.
        if (sync) begin
            vec_lo_next = accept_nmi ? VEC_NMI : VEC_IRQ;
        end

        case (state_reg)
            ST_RUN: begin
                if (stp) begin
                    state_next = ST_STOP;
                end else if (wai) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Wake on any pending source, independent of the I flag.
                if (irq_pend || nmi_pend) begin
                    state_next = ST_RUN;
                end
            end
            ST_STOP: begin
                state_next = ST_STOP;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_RUN;
            vec_lo_reg      <= VEC_RESET;
            nmi_prev_reg    <= 1'b1;
            nmi_pend_reg    <= 1'b0;
            stretch_cnt_reg <= 2'd2;
            cpu_reset_reg   <= 1'b1;
            in_reset_reg    <= 1'b1;
        end else begin
            state_reg    <= state_next;
            vec_lo_reg   <= vec_lo_next;
            nmi_prev_reg <= nmi_sync;
            nmi_pend_reg <= nmi_pend_next;
            in_reset_reg <= 1'b0;
            // cpu_reset stays high for the two cycles following the first
            // edge that samples reset_n high.
            cpu_reset_reg <= (stretch_cnt_reg != 2'd0);
            if (stretch_cnt_reg != 2'd0) begin
                stretch_cnt_reg <= stretch_cnt_reg - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_int_ctl.sv
// -----------------------------------------------------------------------------
// tb_int_ctl -- self-checking bench for int_ctl.
// Directed scenarios followed by a randomized phase; every cycle the DUT
// outputs are compared with a behavioural model that works from the sampled
// pin history, a count of outstanding NMI requests and a run/wait/stop mode.
// -----------------------------------------------------------------------------
module tb_int_ctl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       irq_n;
    logic       nmi_n;
    logic       sync;
    logic       I;
    logic       wai;
    logic       stp;
    logic       irq;
    logic       mask;
    logic [7:0] vec_lo;
    logic       rdy;
    logic       cpu_reset;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int_ctl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .irq_n     (irq_n),
        .nmi_n     (nmi_n),
        .sync      (sync),
        .I         (I),
        .wai       (wai),
        .stp       (stp),
        .irq       (irq),
        .mask      (mask),
        .vec_lo    (vec_lo),
        .rdy       (rdy),
        .cpu_reset (cpu_reset)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_STOP = 2;

    // Pin levels sampled at each clock edge (newest at the back). The core
    // sees a pin level one edge after it was sampled.
    bit         hist_irq[$];
    bit         hist_nmi[$];
    bit         m_nmi_flag  = 1'b0;
    int         m_mode      = M_RUN;
    int         m_since_rel = 0;
    bit         m_in_reset  = 1'b1;
    logic [7:0] m_vec       = 8'hFC;

    function automatic bit m_irq_pend();
        return !hist_irq[hist_irq.size() - 2];
    endfunction

    function automatic bit m_nmi_fall();
        return hist_nmi[hist_nmi.size() - 3] && !hist_nmi[hist_nmi.size() - 2];
    endfunction

    function automatic bit m_nmi_pend();
        return m_nmi_flag || m_nmi_fall();
    endfunction

    function automatic bit exp_irq();
        return m_irq_pend() || m_nmi_pend();
    endfunction

    function automatic bit exp_mask();
        return m_in_reset || (I && !m_nmi_pend());
    endfunction

    function automatic bit exp_rdy();
        return m_mode == M_RUN;
    endfunction

    function automatic bit exp_cpu_reset();
        return m_since_rel <= 2;
    endfunction

    task automatic push_pins(input bit a, input bit b);
        hist_irq.push_back(a);
        hist_nmi.push_back(b);
        while (hist_irq.size() > 3) void'(hist_irq.pop_front());
        while (hist_nmi.size() > 3) void'(hist_nmi.pop_front());
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
        n_checks++;
        assert (got === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    // One clock: predict from pre-edge inputs, advance the model, compare.
    task automatic tick();
        bit s_rst, s_irq, s_nmi, s_sync, s_wai, s_stp;
        bit acc, np, ip, fall;
        int pending;
        s_rst  = reset_n;
        s_irq  = irq_n;
        s_nmi  = nmi_n;
        s_sync = sync;
        s_wai  = wai;
        s_stp  = stp;
        np     = m_nmi_pend();
        ip     = m_irq_pend();
        fall   = m_nmi_fall();
        acc    = s_sync && exp_irq() && !exp_mask() && exp_rdy() && !exp_cpu_reset();
        @(posedge clk);
        if (!s_rst) begin
            m_in_reset  = 1'b1;
            m_since_rel = 0;
            m_vec       = 8'hFC;
            m_mode      = M_RUN;
            m_nmi_flag  = 1'b0;
            for (int k = 0; k < 3; k++) push_pins(1'b1, 1'b1);
        end else begin
            m_in_reset = 1'b0;
            if (m_since_rel < 1000) m_since_rel++;
            if (s_sync) m_vec = (acc && np) ? 8'hFA : 8'hFE;
            pending = int'(m_nmi_flag) + int'(fall);
            if (acc && np) pending--;
            m_nmi_flag = (pending > 0);
            if (m_mode == M_RUN) begin
                if (s_stp) m_mode = M_STOP;
                else if (s_wai) m_mode = M_WAIT;
            end else if (m_mode == M_WAIT) begin
                if (ip || np) m_mode = M_RUN;
            end
            push_pins(s_irq, s_nmi);
        end
        #1;
        check("irq", {7'd0, irq}, {7'd0, exp_irq()});
        check("mask", {7'd0, mask}, {7'd0, exp_mask()});
        check("vec_lo", vec_lo, m_vec);
        check("rdy", {7'd0, rdy}, {7'd0, exp_rdy()});
        check("cpu_reset", {7'd0, cpu_reset}, {7'd0, exp_cpu_reset()});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        for (int k = 0; k < 3; k++) push_pins(1'b1, 1'b1);
        reset_n = 1'b0;
        irq_n   = 1'b1;
        nmi_n   = 1'b1;
        sync    = 1'b0;
        I       = 1'b1;
        wai     = 1'b0;
        stp     = 1'b0;
        ticks(3);
        check("reset_vec", vec_lo, 8'hFC);
        check("reset_mask", {7'd0, mask}, 8'd1);

        // Reset release and cpu_reset stretch
        reset_n = 1'b1;
        tick();
        check("cpu_reset_c0", {7'd0, cpu_reset}, 8'd1);
        tick();
        check("cpu_reset_c1", {7'd0, cpu_reset}, 8'd1);
        tick();
        check("cpu_reset_c2", {7'd0, cpu_reset}, 8'd0);
        ticks(3);
        check("vec_hold_fc", vec_lo, 8'hFC);

        // IRQ masked by I, then accepted once I clears
        irq_n = 1'b0;
        ticks(2);
        check("irq_masked_irq", {7'd0, irq}, 8'd1);
        check("irq_masked_mask", {7'd0, mask}, 8'd1);
        sync = 1'b1;
        tick();
        check("brk_vec", vec_lo, 8'hFE);
        sync = 1'b0;
        I = 1'b0;
        tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        irq_n = 1'b1;
        I = 1'b1;
        ticks(3);

        // NMI held low: exactly one request, bypasses I
        nmi_n = 1'b0;
        ticks(2);
        check("nmi_mask", {7'd0, mask}, 8'd0);
        sync = 1'b1;
        tick();
        check("nmi_vec", vec_lo, 8'hFA);
        sync = 1'b0;
        tick();
        check("nmi_cleared_irq", {7'd0, irq}, 8'd0);
        ticks(17);
        sync = 1'b1;
        tick();
        check("nmi_once_vec", vec_lo, 8'hFE);
        sync = 1'b0;
        nmi_n = 1'b1;
        ticks(3);

        // IRQ and NMI together: NMI wins, IRQ remains
        irq_n = 1'b0;
        nmi_n = 1'b0;
        ticks(2);
        sync = 1'b1;
        tick();
        check("both_vec", vec_lo, 8'hFA);
        check("both_irq", {7'd0, irq}, 8'd1);
        sync = 1'b0;
        ticks(2);
        sync = 1'b1;
        tick();
        check("both_next_vec", vec_lo, 8'hFE);
        sync = 1'b0;
        irq_n = 1'b1;
        nmi_n = 1'b1;
        ticks(3);

        // New NMI edge in the same cycle an older latched NMI is accepted
        nmi_n = 1'b0;
        ticks(3);
        nmi_n = 1'b1;
        ticks(2);
        nmi_n = 1'b0;
        ticks(2);
        sync = 1'b1;
        tick();
        check("nmi_overlap_vec", vec_lo, 8'hFA);
        check("nmi_overlap_pend", {7'd0, irq}, 8'd1);
        sync = 1'b0;
        tick();
        sync = 1'b1;
        tick();
        check("nmi_second_vec", vec_lo, 8'hFA);
        sync = 1'b0;
        nmi_n = 1'b1;
        ticks(3);

        // WAI, woken by IRQ with I set
        wai = 1'b1;
        tick();
        wai = 1'b0;
        check("wai_stall", {7'd0, rdy}, 8'd0);
        ticks(4);
        irq_n = 1'b0;
        ticks(2);
        check("wai_still", {7'd0, rdy}, 8'd0);
        tick();
        check("wai_wake", {7'd0, rdy}, 8'd1);
        irq_n = 1'b1;
        ticks(3);

        // WAI+STP together -> STOP, only reset leaves it
        wai = 1'b1;
        stp = 1'b1;
        tick();
        wai = 1'b0;
        stp = 1'b0;
        irq_n = 1'b0;
        nmi_n = 1'b0;
        ticks(6);
        check("stop_hold", {7'd0, rdy}, 8'd0);
        reset_n = 1'b0;
        tick();
        check("stop_reset_rdy", {7'd0, rdy}, 8'd1);
        check("stop_reset_vec", vec_lo, 8'hFC);
        reset_n = 1'b1;
        irq_n = 1'b1;
        nmi_n = 1'b1;
        ticks(4);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 11) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 7) == 0) I = ~I;
            sync = ($urandom_range(0, 3) == 0);
            wai  = ($urandom_range(0, 39) == 0);
            stp  = ($urandom_range(0, 399) == 0);
            if (reset_n == 1'b0) reset_n = ($urandom_range(0, 1) == 0);
            else reset_n = !($urandom_range(0, 299) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
